// File: rtl/pcf8591_i2c_responder.sv
// I2C target emulating the PCF8591 protocol: control/DAC byte writes and ADC sample reads.
// Build option PCF8591_AUTOINC_EN: advance adc_channel after each sample_req when ctrl_byte[2] is set.
module pcf8591_i2c_responder #(
  parameter logic [6:0]  DEV_ADDR    = 7'h48,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] adc_sample,
  output logic [1:0] adc_channel,
  output logic       sample_req,
  output logic [7:0] ctrl_byte,
  output logic       ctrl_valid,
  output logic [7:0] dac_byte,
  output logic       dac_valid,
  output logic       busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_BYTE,
    S_WR_ACK,
    S_RD_BYTE,
    S_RD_MACK,
    S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;

  logic scl_s;
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  state_t           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [7:0]       rx_q;
  logic [6:0]       tx_q;
  logic             rw_q;
  logic             mack_q;
  logic             first_q;
  logic             sda_oe_q;
  logic             busy_q;
  logic             sample_req_q;
  logic             ctrl_valid_q;
  logic             dac_valid_q;
  logic [7:0]       ctrl_byte_q;
  logic [7:0]       dac_byte_q;
  logic [1:0]       adc_channel_q;

  // Synchronizers reset to the idle-bus level, plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  // Protocol state machine; START/STOP take priority over every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      rx_q          <= '0;
      tx_q          <= '0;
      rw_q          <= 1'b0;
      mack_q        <= 1'b1;
      first_q       <= 1'b0;
      sda_oe_q      <= 1'b0;
      busy_q        <= 1'b0;
      sample_req_q  <= 1'b0;
      ctrl_valid_q  <= 1'b0;
      dac_valid_q   <= 1'b0;
      ctrl_byte_q   <= 8'h00;
      dac_byte_q    <= 8'h00;
      adc_channel_q <= 2'd0;
    end else begin
      sample_req_q <= 1'b0;
      ctrl_valid_q <= 1'b0;
      dac_valid_q  <= 1'b0;
      busy_q       <= (state_q != S_IDLE) && (state_q != S_IGNORE);
`ifdef PCF8591_AUTOINC_EN
      if (sample_req_q && ctrl_byte_q[2]) begin
        adc_channel_q <= adc_channel_q + 2'd1;
      end
`endif
      if (start_det) begin
        state_q   <= S_ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        first_q   <= 1'b1;
      end else if (stop_det) begin
        state_q  <= S_IDLE;
        sda_oe_q <= 1'b0;
      end else begin
        case (state_q)
          S_ADDR: begin
            if (scl_rise) begin
              rx_q      <= {rx_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end else if (scl_fall && (bit_cnt_q == LAST_BIT)) begin
              if (rx_q[7:1] == DEV_ADDR) begin
                state_q  <= S_ADDR_ACK;
                sda_oe_q <= 1'b1;
                rw_q     <= rx_q[0];
              end else begin
                state_q  <= S_IGNORE;
                sda_oe_q <= 1'b0;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (rw_q) begin
                tx_q         <= adc_sample[6:0];
                sda_oe_q     <= ~adc_sample[7];
                sample_req_q <= 1'b1;
                bit_cnt_q    <= CNT_W'(1);
                state_q      <= S_RD_BYTE;
              end else begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
                state_q   <= S_WR_BYTE;
              end
            end
          end
          S_WR_BYTE: begin
            if (scl_rise) begin
              rx_q      <= {rx_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end else if (scl_fall && (bit_cnt_q == LAST_BIT)) begin
              // Byte is complete: commit it and ACK from this fall to the next.
              sda_oe_q <= 1'b1;
              state_q  <= S_WR_ACK;
              first_q  <= 1'b0;
              if (first_q) begin
                ctrl_byte_q   <= rx_q;
                ctrl_valid_q  <= 1'b1;
                adc_channel_q <= rx_q[1:0];
              end else begin
                dac_byte_q  <= rx_q;
                dac_valid_q <= 1'b1;
              end
            end
          end
          S_WR_ACK: begin
            if (scl_fall) begin
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= '0;
              state_q   <= S_WR_BYTE;
            end
          end
          S_RD_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt_q == LAST_BIT) begin
                sda_oe_q <= 1'b0;
                state_q  <= S_RD_MACK;
              end else begin
                sda_oe_q  <= ~tx_q[6];
                tx_q      <= {tx_q[5:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              end
            end
          end
          S_RD_MACK: begin
            if (scl_rise) begin
              mack_q <= sda_s;
            end else if (scl_fall) begin
              if (!mack_q) begin
                tx_q         <= adc_sample[6:0];
                sda_oe_q     <= ~adc_sample[7];
                sample_req_q <= 1'b1;
                bit_cnt_q    <= CNT_W'(1);
                state_q      <= S_RD_BYTE;
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= S_IGNORE;
              end
            end
          end
          default: begin
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe      = sda_oe_q;
  assign busy        = busy_q;
  assign sample_req  = sample_req_q;
  assign ctrl_valid  = ctrl_valid_q;
  assign dac_valid   = dac_valid_q;
  assign ctrl_byte   = ctrl_byte_q;
  assign dac_byte    = dac_byte_q;
  assign adc_channel = adc_channel_q;

endmodule
